psa_seq_ctrl: RTL



---
 rtl/psa_seq_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/psa_seq_ctrl.sv
// Multi-cycle parallel sub-word add: one shared 4-bit signed adder lane walks
// the four nibbles of A and B, producing a packed 16-bit Sum and an aggregate Error.
module psa_seq_ctrl #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        ready,
    output logic        done,
    output logic [15:0] Sum,
    output logic        Error
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [3:0]  lane_a;
    logic [3:0]  lane_b;
    logic [3:0]  lane_raw;
    logic [3:0]  lane_res;
    logic        lane_ovf;

    // Shared lane: signed overflow when both operands agree in sign but the result does not.
    always_comb begin
        lane_a   = a_reg[{idx, 2'b00} +: 4];
        lane_b   = b_reg[{idx, 2'b00} +: 4];
        lane_raw = lane_a + lane_b;
        lane_ovf = (lane_a[3] == lane_b[3]) && (lane_raw[3] != lane_a[3]);
        lane_res = lane_raw;
        if (lane_ovf && SATURATE) begin
            lane_res = lane_a[3] ? 4'h8 : 4'h7;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
            ready <= 1'b1;
            done  <= 1'b0;
            Sum   <= 16'h0000;
            Error <= 1'b0;
            a_reg <= 16'h0000;
            b_reg <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        Sum   <= 16'h0000;
                        Error <= 1'b0;
                        idx   <= 2'd0;
                        ready <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    Sum[{idx, 2'b00} +: 4] <= lane_res;
                    Error                  <= Error | lane_ovf;
                    if (idx == 2'd3) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    idx   <= 2'd0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    idx   <= 2'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
